router_sync: RTL and testbench
==============================

ROUTER_SYNC -- requirements
Module: router_sync

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 30, meaning consecutive unread-valid cycles before a channel's soft reset; legal range 2..31.
REQ-002 The block SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port detect_add, input, 1, high for one cycle while a packet header is on data_in.
REQ-005 The block SHALL have port data_in, input, 2, destination address field, header bits [1:0].
REQ-006 The block SHALL have port write_enb_reg, input, 1, write request from the router controller.
REQ-007 The block SHALL have ports read_enb_0/1/2, input, 1 each, read strobes from the output ports.
REQ-008 The block SHALL have ports full_0/1/2 and empty_0/1/2, input, 1 each, status from the three router_fifo instances.
REQ-009 The block SHALL have port write_enb, output, 3, one-hot write enable to FIFO 0/1/2 (bit n = FIFO n).
REQ-010 The block SHALL have port fifo_full, output, 1, full flag of the currently addressed FIFO.
REQ-011 The block SHALL have ports vld_out_0/1/2, output, 1 each, data-available indication per output port.
REQ-012 The block SHALL have ports soft_reset_0/1/2, output, 1 each, registered one-cycle flush pulse to FIFO n.

Function
REQ-013 Address register addr (2 bits) SHALL load data_in on a rising edge with detect_add=1, else hold; new value visible the cycle after capture.
REQ-014 write_enb SHALL be combinational: 001/010/100 for addr 0/1/2 when write_enb_reg=1; 000 when write_enb_reg=0 or addr=3.
REQ-015 fifo_full SHALL combinationally equal full_<addr> for addr 0..2 and 0 for addr=3.
REQ-016 vld_out_n SHALL combinationally equal ~empty_n.
REQ-017 Each channel n SHALL have a 5-bit timer cnt_n; on each edge: if vld_out_n=0 or read_enb_n=1 then cnt_n<=0, soft_reset_n<=0.
REQ-018 Else if cnt_n==TIMEOUT-1 then cnt_n<=0, soft_reset_n<=1; else cnt_n<=cnt_n+1, soft_reset_n<=0.
REQ-019 Thus soft_reset_n SHALL rise after exactly TIMEOUT consecutive edges with vld_out_n=1 and read_enb_n=0, and last exactly one cycle.
REQ-020 If vld_out_n remains 1 and unread after a pulse, counting SHALL restart from 0 and pulse again TIMEOUT edges later.
REQ-021 A single cycle of read_enb_n=1 SHALL clear cnt_n; a pending expiry on that edge SHALL be cancelled (read wins).
REQ-022 Channels SHALL be fully independent; simultaneous expiries SHALL pulse all affected soft_reset_n on the same edge.
REQ-023 detect_add concurrent with write_enb_reg SHALL steer that cycle's write by the old addr.
REQ-024 No timer SHALL wrap: cnt_n never exceeds TIMEOUT-1.

Reset
REQ-025 resetn=0 SHALL asynchronously force addr=0, all cnt_n=0, all soft_reset_n=0.
REQ-026 During reset, write_enb SHALL follow REQ-014 with addr=0; vld_out_n and fifo_full SHALL follow inputs.
REQ-027 Reset asserted mid-count SHALL discard the count; counting resumes from 0 after the first edge with resetn=1.

Structure
REQ-028 TIMEOUT default, timer width (5) and address encodings (0,1,2, 3=invalid) SHALL live in a shared router_defs include used by router_fsm, router_sync and router_fifo.
REQ-029 The per-channel timer SHALL be one sub-module, router_sync_timer (inputs clock, resetn, vld, rd; output soft_reset), instantiated three times.

Verification
REQ-030 detect_add=1, data_in=2'b01, then write_enb_reg=1 -> write_enb=010 from next cycle; full_1=1 -> fifo_full=1.
REQ-031 data_in=2'b11 captured, write_enb_reg=1, full_0..2=111 -> write_enb=000, fifo_full=0.
REQ-032 empty_0=0, read_enb_0=0 held 30 edges -> soft_reset_0=1 on cycle after edge 30 only, 0 on edge 31.
REQ-033 empty_2=0, read_enb_2 pulsed at edge 29 -> no soft_reset_2; pulse occurs 30 edges after the read.
REQ-034 empty_0=empty_1=0 with equal start, no reads -> soft_reset_0 and soft_reset_1 pulse on same edge; soft_reset_2 stays 0.
REQ-035 resetn driven low at count 20 between edges -> soft_reset and counts 0 immediately; after release, pulse requires 30 fresh edges.

Source files
------------

// File: rtl/router_sync_pkg.sv
// Shared router definitions: default timeout, timer width and destination address encodings.
// Used by router_sync and its per-channel timers.
package router_sync_pkg;

  localparam int TIMEOUT_DEF = 30;
  localparam int TIMER_W     = 5;

  typedef enum logic [1:0] {
    ADDR_P0  = 2'd0,
    ADDR_P1  = 2'd1,
    ADDR_P2  = 2'd2,
    ADDR_INV = 2'd3
  } addr_e;

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel unread-data watchdog: pulses soft_reset for one cycle after
// TIMEOUT consecutive edges with data valid and no read.
module router_sync_timer
  import router_sync_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  logic [TIMER_W-1:0] r_cnt;
  logic               r_soft_reset;

  // A read on the expiry edge cancels the pulse: the idle/read branch has priority.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (!vld || rd) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (r_cnt == TIMER_W'(TIMEOUT - 1)) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b1;
    end else begin
      r_cnt        <= r_cnt + TIMER_W'(1);
      r_soft_reset <= 1'b0;
    end
  end

  assign soft_reset = r_soft_reset;

endmodule

// File: rtl/router_sync.sv
// Router synchronizer: latches the packet destination, steers FIFO writes,
// reports per-port valid and flushes FIFOs whose data sits unread too long.
module router_sync
  import router_sync_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  addr_e r_addr;

  // Header capture takes effect next cycle, so a concurrent write uses the old address.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_addr <= ADDR_P0;
    else if (detect_add)
      r_addr <= addr_e'(data_in);
  end

  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (r_addr)
      ADDR_P0: begin
        write_enb = write_enb_reg ? 3'b001 : 3'b000;
        fifo_full = full_0;
      end
      ADDR_P1: begin
        write_enb = write_enb_reg ? 3'b010 : 3'b000;
        fifo_full = full_1;
      end
      ADDR_P2: begin
        write_enb = write_enb_reg ? 3'b100 : 3'b000;
        fifo_full = full_2;
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

  router_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer_0 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_0),
    .rd         (read_enb_0),
    .soft_reset (soft_reset_0)
  );

  router_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer_1 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_1),
    .rd         (read_enb_1),
    .soft_reset (soft_reset_1)
  );

  router_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer_2 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_2),
    .rd         (read_enb_2),
    .soft_reset (soft_reset_2)
  );

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync with default TIMEOUT of 30.
module tb_router_sync;

  logic       clock = 1'b0;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       full_0, full_1, full_2;
  logic       empty_0, empty_1, empty_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  int tests_run = 0;
  int tests_failed = 0;

  router_sync dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (read_enb_0),
    .read_enb_1    (read_enb_1),
    .read_enb_2    (read_enb_2),
    .full_0        (full_0),
    .full_1        (full_1),
    .full_2        (full_2),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] sr();
    return {soft_reset_2, soft_reset_1, soft_reset_0};
  endfunction

  task automatic negs(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    resetn = 1'b0; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b1;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;
    empty_0 = 1'b1; empty_1 = 1'b0; empty_2 = 1'b1;

    // Reset state: addr=0 steering, valid follows empty, no pulses
    #12;
    check("rst_write_enb", write_enb, 3'b001);
    check("rst_soft_reset", sr(), 3'b000);
    check("rst_vld_out", {vld_out_2, vld_out_1, vld_out_0}, 3'b010);
    full_0 = 1'b1; #1;
    check("rst_fifo_full", {2'b00, fifo_full}, 3'b001);
    full_0 = 1'b0; empty_1 = 1'b1; write_enb_reg = 1'b0;
    @(negedge clock);
    resetn = 1'b1;

    // Address 1 capture, then write and full steering
    @(negedge clock);
    detect_add = 1'b1; data_in = 2'b01; #1;
    check("cap1_no_write", write_enb, 3'b000);
    @(negedge clock);
    detect_add = 1'b0; write_enb_reg = 1'b1; #1;
    check("addr1_write_enb", write_enb, 3'b010);
    full_1 = 1'b1; #1;
    check("addr1_fifo_full", {2'b00, fifo_full}, 3'b001);
    full_1 = 1'b0; full_0 = 1'b1; full_2 = 1'b1; #1;
    check("addr1_other_full", {2'b00, fifo_full}, 3'b000);
    full_0 = 1'b0; full_2 = 1'b0;

    // Header concurrent with write uses the old address
    @(negedge clock);
    detect_add = 1'b1; data_in = 2'b10; #1;
    check("concurrent_old_addr", write_enb, 3'b010);
    @(negedge clock);
    detect_add = 1'b0; #1;
    check("addr2_write_enb", write_enb, 3'b100);
    full_2 = 1'b1; #1;
    check("addr2_fifo_full", {2'b00, fifo_full}, 3'b001);

    // Invalid address 3 blocks writes and masks full
    @(negedge clock);
    detect_add = 1'b1; data_in = 2'b11;
    @(negedge clock);
    detect_add = 1'b0; full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1; #1;
    check("addr3_write_enb", write_enb, 3'b000);
    check("addr3_fifo_full", {2'b00, fifo_full}, 3'b000);
    write_enb_reg = 1'b0; #1;
    check("no_wer_write_enb", write_enb, 3'b000);
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

    // Channel 0 timeout: pulse after edge 30 only, repeat 30 edges later
    @(negedge clock);
    empty_0 = 1'b0; #1;
    check("vld_out_0", {2'b00, vld_out_0}, 3'b001);
    negs(29);
    check("ch0_edge29", sr(), 3'b000);
    negs(1);
    check("ch0_edge30", sr(), 3'b001);
    negs(1);
    check("ch0_edge31", sr(), 3'b000);
    negs(28);
    check("ch0_edge59", sr(), 3'b000);
    negs(1);
    check("ch0_edge60", sr(), 3'b001);
    empty_0 = 1'b1;
    negs(1);
    check("ch0_idle", sr(), 3'b000);

    // Channel 2: read at edge 29 restarts the count
    empty_2 = 1'b0;
    negs(28);
    read_enb_2 = 1'b1;
    negs(1);
    read_enb_2 = 1'b0;
    check("ch2_read_edge29", sr(), 3'b000);
    negs(1);
    check("ch2_edge30_no_pulse", sr(), 3'b000);
    negs(28);
    check("ch2_edge58", sr(), 3'b000);
    negs(1);
    check("ch2_edge59_pulse", sr(), 3'b100);
    // Read on the expiry edge cancels the pulse
    negs(29);
    read_enb_2 = 1'b1;
    negs(1);
    read_enb_2 = 1'b0;
    check("ch2_read_wins", sr(), 3'b000);
    empty_2 = 1'b1;
    negs(1);

    // Channels 0 and 1 expire together
    empty_0 = 1'b0; empty_1 = 1'b0;
    negs(29);
    check("dual_edge29", sr(), 3'b000);
    negs(1);
    check("dual_edge30", sr(), 3'b011);
    empty_0 = 1'b1; empty_1 = 1'b1;
    negs(1);

    // Reset mid-count discards the count
    detect_add = 1'b1; data_in = 2'b10;
    negs(1);
    detect_add = 1'b0;
    empty_0 = 1'b0;
    negs(20);
    #2 resetn = 1'b0; write_enb_reg = 1'b1; #1;
    check("midrst_soft_reset", sr(), 3'b000);
    check("midrst_write_enb", write_enb, 3'b001);
    write_enb_reg = 1'b0;
    negs(2);
    resetn = 1'b1;
    negs(29);
    check("postrst_edge29", sr(), 3'b000);
    negs(1);
    check("postrst_edge30", sr(), 3'b001);
    // Asynchronous reset clears a live pulse immediately
    #1 resetn = 1'b0; #1;
    check("async_clear_pulse", sr(), 3'b000);
    empty_0 = 1'b1;
    negs(1);
    resetn = 1'b1;
    negs(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
